// File: rtl/if_id_skid_reg.sv
// ---------------------------------------------------------------------------
// if_id_skid_reg
//
// IF/ID pipeline register built as a 2-entry skid buffer. Fetch pushes
// {PC+4, instruction} pairs with a valid/ready handshake, and decode pops the
// head entry. The second slot absorbs the instruction that fetch already
// produced in the cycle decode stalled, so nothing is lost while the freeze
// (~in_ready) propagates back to fetch.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : branch taken in execute; drop everything buffered/incoming
//   pc_in, instruction_in, in_valid / in_ready    : fetch side handshake
//   pc_out, instruction_out, out_valid / out_ready : decode side handshake
//   stall_cycles      : saturating count of cycles with out_valid & ~out_ready
//
// Parameters
//   DEPTH : number of buffered entries (only 2 is supported)
//   CNT_W : width of the stall-cycle counter
// ---------------------------------------------------------------------------
module if_id_skid_reg #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      instruction_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      pc_out,
    output logic [31:0]      instruction_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stall_cycles
);

    // Encoding equals the occupancy count, so bit 0 doubles as count mod 2.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic             r_head;
    logic [31:0]      r_pc    [DEPTH];
    logic [31:0]      r_instr [DEPTH];
    logic [CNT_W-1:0] r_stall;

    logic             w_push;
    logic             w_pop;
    logic             w_wr_ptr;
    logic             w_out_valid;
    logic             w_in_ready;

    // Handshake flags come from registered state only: out_ready never
    // reaches in_ready combinationally, which keeps the fetch freeze path short.
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_in_ready  = (r_state != S_FULL);

    assign w_push = in_valid & w_in_ready;
    assign w_pop  = w_out_valid & out_ready;

    // Write slot = head + count (mod 2). Only meaningful when not FULL,
    // which is the only time a push can happen.
    assign w_wr_ptr = r_head ^ r_state[0];

    // -----------------------------------------------------------------------
    // Occupancy FSM and head pointer. Flush wins over push and pop; a pop in
    // the flush cycle is treated as consumed and simply forgotten here.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_head  <= 1'b0;
        end else if (flush) begin
            r_state <= S_EMPTY;
            r_head  <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push)
                        r_state <= S_ONE;
                end
                S_ONE: begin
                    // push & pop together stays in ONE; the new entry
                    // becomes head because the head pointer toggles below.
                    if (w_push && !w_pop)
                        r_state <= S_FULL;
                    else if (!w_push && w_pop)
                        r_state <= S_EMPTY;
                end
                S_FULL: begin
                    // in_valid is ignored here since in_ready is low.
                    if (w_pop)
                        r_state <= S_ONE;
                end
                default: r_state <= S_EMPTY;
            endcase
            if (w_pop)
                r_head <= ~r_head;
        end
    end

    // -----------------------------------------------------------------------
    // Entry storage. A pair offered during flush is discarded.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
        end else if (w_push && !flush) begin
            r_pc[w_wr_ptr]    <= pc_in;
            r_instr[w_wr_ptr] <= instruction_in;
        end
    end

    // -----------------------------------------------------------------------
    // Stall counter: counts held-head cycles, including a flush cycle, and
    // sticks at all-ones. Only reset clears it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall <= '0;
        else if (w_out_valid && !out_ready && (r_stall != CNT_MAX))
            r_stall <= r_stall + CNT_ONE;
    end

    // Data outputs are forced to zero when empty so stale slots never leak.
    assign out_valid       = w_out_valid;
    assign in_ready        = w_in_ready;
    assign pc_out          = w_out_valid ? r_pc[r_head]    : 32'd0;
    assign instruction_out = w_out_valid ? r_instr[r_head] : 32'd0;
    assign stall_cycles    = r_stall;

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] pc_in;
    logic [31:0] instruction_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] stall_cycles;

    // second instance with a narrow counter for the saturation scenario
    logic        s_flush;
    logic [31:0] s_pc_in;
    logic [31:0] s_instr_in;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_pc_out;
    logic [31:0] s_instr_out;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [3:0]  s_stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_id_skid_reg #(.DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .pc_in(pc_in), .instruction_in(instruction_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_out(pc_out), .instruction_out(instruction_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .stall_cycles(stall_cycles)
    );

    if_id_skid_reg #(.DEPTH(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush(s_flush),
        .pc_in(s_pc_in), .instruction_in(s_instr_in),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .pc_out(s_pc_out), .instruction_out(s_instr_out),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .stall_cycles(s_stall)
    );

    // Reference model: a bounded queue of fetched pairs plus a stall tally.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_stall;

    function automatic logic [31:0] exp_pc();
        return (mq.size() > 0) ? mq[0].pc : 32'd0;
    endfunction

    function automatic logic [31:0] exp_ins();
        return (mq.size() > 0) ? mq[0].ins : 32'd0;
    endfunction

    task automatic model_edge();
        bit   has   = (mq.size() > 0);
        bit   room  = (mq.size() < 2);
        ent_t e;
        if (rst) begin
            mq.delete();
            m_stall = 0;
        end else begin
            if (has && !out_ready && m_stall < 65535) m_stall++;
            if (flush) mq.delete();
            else begin
                if (has && out_ready) void'(mq.pop_front());
                if (in_valid && room) begin
                    e.pc  = pc_in;
                    e.ins = instruction_in;
                    mq.push_back(e);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; out_ready = 0; pc_in = 0; instruction_in = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        s_flush = 0; s_in_valid = 0; s_out_ready = 0; s_pc_in = 0; s_instr_in = 0;
        mq.delete(); m_stall = 0;
        repeat (3) tick();
        rst = 0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
        end
        n_checks++;
        if (pc_out !== 32'd0 || instruction_out !== 32'd0 || stall_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: pc=%h ins=%h stall=%0d, expected zeros", pc_out, instruction_out, stall_cycles);
        end
    endtask

    task automatic test_streaming();
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            pc_in = 32'(4 * (i + 1));
            instruction_in = $urandom;
            tick();
            n_checks++;
            if (pc_out !== 32'(4 * (i + 1)) || instruction_out !== exp_ins() || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_data[%0d]: pc=%h ins=%h v=%b, expected pc=%h ins=%h v=1",
                         i, pc_out, instruction_out, out_valid, 4 * (i + 1), exp_ins());
            end
            n_checks++;
            if (in_ready !== 1'b1 || stall_cycles !== 16'd0) begin
                n_fail++;
                $display("FAIL stream_flow[%0d]: in_ready=%b stall=%0d, expected 1/0", i, in_ready, stall_cycles);
            end
        end
        in_valid = 0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_stall_fill();
        int unsigned s0 = m_stall;
        out_ready = 0; in_valid = 1;
        pc_in = 32'h10; instruction_in = 32'hE3A01005; tick();
        pc_in = 32'h14; instruction_in = 32'hE2811001; tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || pc_out !== 32'h10 || instruction_out !== 32'hE3A01005) begin
            n_fail++;
            $display("FAIL fill_full: in_ready=%b v=%b pc=%h ins=%h, expected 0/1/10/e3a01005",
                     in_ready, out_valid, pc_out, instruction_out);
        end
        pc_in = 32'h18; instruction_in = 32'hDEADBEEF;
        repeat (3) tick();
        n_checks++;
        if (in_ready !== 1'b0 || pc_out !== 32'h10) begin
            n_fail++;
            $display("FAIL fill_hold: in_ready=%b pc=%h, expected 0/10", in_ready, pc_out);
        end
        in_valid = 0; out_ready = 1;
        tick();
        n_checks++;
        if (pc_out !== 32'h14 || instruction_out !== 32'hE2811001 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_second: pc=%h ins=%h v=%b, expected 14/e2811001/1", pc_out, instruction_out, out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || pc_out !== 32'd0) begin
            n_fail++;
            $display("FAIL fill_empty: v=%b pc=%h, expected 0/0 (0x18 must have been ignored)", out_valid, pc_out);
        end
        n_checks++;
        if (stall_cycles !== 16'(s0 + 4)) begin
            n_fail++;
            $display("FAIL fill_stall: got %0d expected %0d", stall_cycles, s0 + 4);
        end
    endtask

    task automatic test_push_pop();
        out_ready = 0; in_valid = 1; pc_in = 32'h20; instruction_in = 32'h11112222;
        tick();
        pc_in = 32'h24; instruction_in = 32'h33334444; out_ready = 1;
        tick();
        in_valid = 0; out_ready = 0;
        n_checks++;
        if (pc_out !== 32'h24 || instruction_out !== 32'h33334444 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pushpop: pc=%h ins=%h v=%b r=%b, expected 24/33334444/1/1",
                     pc_out, instruction_out, out_valid, in_ready);
        end
        out_ready = 1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_drain: v=%b expected 0 (count should have been 1)", out_valid);
        end
    endtask

    task automatic test_flush();
        int unsigned s0 = m_stall;
        out_ready = 0; in_valid = 1;
        pc_in = 32'h30; instruction_in = 32'hA; tick();
        pc_in = 32'h34; instruction_in = 32'hB; tick();
        flush = 1; pc_in = 32'h40; instruction_in = 32'hC;
        tick();
        flush = 0; in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || pc_out !== 32'd0 || instruction_out !== 32'd0) begin
            n_fail++;
            $display("FAIL flush_clear: v=%b r=%b pc=%h ins=%h, expected 0/1/0/0", out_valid, in_ready, pc_out, instruction_out);
        end
        // held edge before flush + the flush edge itself
        n_checks++;
        if (stall_cycles !== 16'(s0 + 2)) begin
            n_fail++;
            $display("FAIL flush_stall: got %0d expected %0d", stall_cycles, s0 + 2);
        end
        in_valid = 1; pc_in = 32'h80; instruction_in = 32'h80808080;
        tick();
        pc_in = 32'h84; instruction_in = 32'h84848484;
        tick();
        in_valid = 0;
        n_checks++;
        if (pc_out !== 32'h80 || instruction_out !== 32'h80808080) begin
            n_fail++;
            $display("FAIL flush_refill: pc=%h ins=%h, expected 80/80808080", pc_out, instruction_out);
        end
        out_ready = 1;
        tick();
        n_checks++;
        if (pc_out !== 32'h84) begin
            n_fail++;
            $display("FAIL flush_second: pc=%h expected 84", pc_out);
        end
        tick();
        out_ready = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            flush          = ($urandom_range(0, 15) == 0);
            pc_in          = $urandom;
            instruction_in = $urandom;
            tick();
            n_checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
                pc_out !== exp_pc() || instruction_out !== exp_ins() || stall_cycles !== 16'(m_stall)) begin
                n_fail++;
                $display("FAIL random[%0d]: v=%b r=%b pc=%h ins=%h st=%0d, expected v=%b r=%b pc=%h ins=%h st=%0d",
                         i, out_valid, in_ready, pc_out, instruction_out, stall_cycles,
                         mq.size() > 0, mq.size() < 2, exp_pc(), exp_ins(), m_stall);
            end
        end
        in_valid = 0; flush = 1;
        tick();
        flush = 0; out_ready = 0;
    endtask

    task automatic test_saturation();
        s_out_ready = 0; s_in_valid = 1; s_pc_in = 32'h50; s_instr_in = 32'h5050;
        tick();
        s_in_valid = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_checks++;
            if (s_stall !== 4'((k > 15) ? 15 : k) || s_out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL saturate[%0d]: stall=%0d v=%b, expected %0d/1", k, s_stall, s_out_valid, (k > 15) ? 15 : k);
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 0; in_valid = 1;
        pc_in = 32'h60; instruction_in = 32'h6; tick();
        pc_in = 32'h64; instruction_in = 32'h7; tick();
        in_valid = 0;
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || stall_cycles === 16'd0) begin
            n_fail++;
            $display("FAIL areset_pre: in_ready=%b stall=%0d, expected 0/nonzero", in_ready, stall_cycles);
        end
        #2 rst = 1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || pc_out !== 32'd0 ||
            instruction_out !== 32'd0 || stall_cycles !== 16'd0 || s_stall !== 4'd0) begin
            n_fail++;
            $display("FAIL areset: v=%b r=%b pc=%h ins=%h st=%0d sst=%0d, expected 0/1/0/0/0/0",
                     out_valid, in_ready, pc_out, instruction_out, stall_cycles, s_stall);
        end
        mq.delete(); m_stall = 0;
        tick();
        rst = 0;
        in_valid = 1; out_ready = 1; pc_in = 32'h100; instruction_in = 32'h1234;
        tick();
        in_valid = 0;
        n_checks++;
        if (pc_out !== 32'h100 || out_valid !== 1'b1 || stall_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL areset_after: pc=%h v=%b st=%0d, expected 100/1/0", pc_out, out_valid, stall_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_fill();
        test_push_pop();
        test_flush();
        test_random();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Pipeline register between the instruction-fetch stage and the instruction-decode stage.
- Captures the fetched PC+4 and instruction word.
- Implemented as a 2-entry skid buffer with valid/ready handshake, so a decode stall does not lose an instruction already fetched in that cycle.
- Supports branch flush from the execute stage and provides a saturating stall-cycle counter for performance debug.

Parameters:
- DEPTH, 2, number of buffered entries; fixed at 2; other values unsupported.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- flush  input  1  branch taken in execute; discard all buffered and incoming entries.
- pc_in  input  32  PC+4 value from fetch.
- instruction_in  input  32  fetched instruction word.
- in_valid  input  1  fetch presents a valid pair this cycle.
- in_ready  output  1  buffer can accept; fetch uses ~in_ready as its freeze.
- pc_out  output  32  PC+4 of the head entry.
- instruction_out  output  32  instruction of the head entry.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes head this cycle; driven low by the hazard unit.
- stall_cycles  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (async, rst=1):
  - count=0, head pointer=0, both entries zeroed.
  - out_valid=0, in_ready=1, pc_out=0, instruction_out=0, stall_cycles=0.
  - Reset mid-operation drops all entries immediately.
- State is count in {0,1,2}:
  - EMPTY (0): out_valid=0, in_ready=1.
  - ONE (1): out_valid=1, in_ready=1.
  - FULL (2): out_valid=1, in_ready=0.
- in_ready and out_valid are decoded from registered count only. There is no combinational path from out_ready to in_ready.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions without flush:
  - EMPTY: push -> ONE.
  - ONE: push & ~pop -> FULL; ~push & pop -> EMPTY; push & pop -> ONE (new entry becomes head next cycle); neither -> ONE.
  - FULL: pop -> ONE (second entry becomes head); ~pop -> FULL. in_valid is ignored while FULL.
- Entries form a circular 2-slot FIFO.
  - Write pointer = head + count, modulo 2.
  - Head pointer toggles on pop.
  - All pointer arithmetic wraps modulo 2.
- Latency: a pair pushed in cycle N appears on pc_out/instruction_out with out_valid=1 in cycle N+1 at the earliest. There is no same-cycle bypass.
- Outputs when count=0: pc_out=0 and instruction_out=0, regardless of stale storage.
- Flush:
  - Has priority over push and pop.
  - On the next edge: count=0 and head pointer=0.
  - Any in_valid pair in the flush cycle is discarded.
  - A pop that coincides with flush is still considered consumed by decode; the buffer does not track it further.
  - in_ready is 1 in the cycle after flush.
- stall_cycles:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0, including the flush cycle.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by rst.
- Data widths are fixed at 32 bits; there is no arithmetic on the data path.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with count=2 -> out_valid=0, in_ready=1, pc_out=0, instruction_out=0, stall_cycles=0 without waiting for a clock edge.
- Streaming: in_valid=1 and out_ready=1 every cycle, pc_in=4,8,12,... -> pc_out follows one cycle later, in_ready stays 1, stall_cycles stays 0.
- Stall fill:
  - Push pc 0x10/instr 0xE3A01005, then pc 0x14/instr 0xE2811001, with out_ready=0 -> count reaches 2, in_ready=0.
  - A third pair (pc 0x18) is ignored.
  - Release out_ready -> outputs 0x10, then 0x14, then out_valid=0.
  - stall_cycles equals the number of held cycles.
- Simultaneous push/pop at ONE: head pc 0x20, push pc 0x24 with out_ready=1 -> next cycle head=0x24, count=1.
- Flush with count=2 and in_valid=1 (pc 0x40) -> next cycle out_valid=0, in_ready=1, pc_out=0. The next push of pc 0x80 emerges first.
- Counter saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cycles=15 and stays at 15.
